// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial MSB-first magnitude comparator:
// FSM state encoding, counter width helper and one-hot verdict encoding.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Counter width for WIDTH pairs; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/serial_bit_counter.sv
// Up-counter of accepted bit pairs with synchronous clear, enable and a
// terminal-count flag that is high while the count equals WIDTH-1.
module serial_bit_counter
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_msb_comparator.sv
// Serial MSB-first unsigned comparator producing a held gt/eq/lt verdict.
// Optional SERIAL_CMP_EARLY_DONE_EN: finish on the first differing pair.
module serial_msb_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic bit_a,
  input  logic bit_b,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e     state_q;
  logic       decided_q;
  logic       dir_q;
  logic       decided_d;
  logic       dir_d;
  logic       diff_s;
  logic       accept_s;
  logic       finish_s;
  logic       tc_s;
  logic [2:0] verdict_d;

  always_comb begin
    diff_s    = bit_a ^ bit_b;
    decided_d = decided_q | diff_s;
    dir_d     = decided_q ? dir_q : bit_a;
    if (decided_d) begin
      verdict_d = dir_d ? RES_GT : RES_LT;
    end else begin
      verdict_d = RES_EQ;
    end
    accept_s = (state_q == COMPARE) && bit_valid;
`ifdef SERIAL_CMP_EARLY_DONE_EN
    finish_s = tc_s | (~decided_q & diff_s);
`else
    finish_s = tc_s;
`endif
  end

  // Counter restarts on every start and on completion so the next run begins at zero.
  serial_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (start | (accept_s & finish_s)),
    .en_i  (accept_s),
    .tc_o  (tc_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else if (start) begin
      state_q   <= COMPARE;
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
        end
        COMPARE: begin
          if (bit_valid) begin
            decided_q <= decided_d;
            dir_q     <= dir_d;
            if (finish_s) begin
              state_q      <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              {gt, eq, lt} <= verdict_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_msb_comparator.sv
// Self-checking bench: directed vector table, hand-written abort/reset
// sequences and randomized operands against an arithmetic reference model.
module tb_serial_msb_comparator;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start, bit_valid, bit_a, bit_b;
  logic busy, done, gt, eq, lt;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           toggle;
    logic [2:0]   exp;
  } vec_t;

  vec_t vecs[5];

  serial_msb_comparator #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .bit_a(bit_a), .bit_b(bit_b), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Edges after the start edge until done becomes visible.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle);
    int pairs;
    logic [W-1:0] x;
    pairs = W;
`ifdef SERIAL_CMP_EARLY_DONE_EN
    x = a ^ b;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) begin
        pairs = W - i;
        break;
      end
    end
`else
    x = '0;
    if (a != b) x = a ^ b;
`endif
    return toggle ? 2 * pairs : pairs;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_a     = 1'($urandom);
    bit_b     = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("start_state", {29'd0, busy, done, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("start_flags", {29'd0, gt, eq, lt}, 32'd0);
  endtask

  // Present pairs MSB-first; returns edge count at done or -1 if max_edges pass.
  task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                      input int max_edges, output int lat, output bit busy_ok);
    int idx;
    idx     = 0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= max_edges; k++) begin
      bit_valid = toggle ? (k % 2 == 0) : 1'b1;
      if (idx >= W) bit_valid = 1'b0;
      if (bit_valid) begin
        bit_a = a[W-1-idx];
        bit_b = b[W-1-idx];
      end else begin
        bit_a = 1'($urandom);
        bit_b = 1'($urandom);
      end
      @(negedge clk);
      if (bit_valid) idx++;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit toggle, input logic [2:0] exp);
    int lat;
    bit bok;
    n_vec++;
    do_start();
    feed(a, b, toggle, 2 * W + 4, lat, bok);
    check({tag, "_latency"}, lat, model_lat(a, b, toggle));
    check({tag, "_verdict"}, {29'd0, gt, eq, lt}, {29'd0, exp});
    check({tag, "_busy"}, {31'd0, bok}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    logic [W-1:0] ra, rb;
    bit tg;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'b100};
    vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b010};
    vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b001};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 3'b100};
    vecs[4] = '{32'h0000_0005, 32'h0000_0009, 1'b0, 3'b001};

    reset = 1'b0; start = 1'b1; bit_valid = 1'b1; bit_a = 1'b1; bit_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {27'd0, busy, done, gt, eq, lt}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].toggle, vecs[i].exp);
      if (i == 1) begin
        repeat (5) @(negedge clk);
        check("eq_held", {29'd0, gt, eq, lt}, 32'd2);
      end
    end

    // Abort after 10 accepted pairs, then restart with A=5, B=9.
    n_vec++;
    do_start();
    feed(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 10, lat, bok);
    check("abort_no_done", lat, -1);
    run_vec("restart", 32'd5, 32'd9, 1'b0, 3'b001);

    // Reset mid-comparison after 20 pairs.
    n_vec++;
    do_start();
    feed(32'h1234_5678, 32'h1234_5678, 1'b0, 20, lat, bok);
    check("pre_reset_no_done", lat, -1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {27'd0, busy, done}, 32'd0);
    run_vec("after_reset", 32'h0000_0100, 32'h0000_0200, 1'b0, 3'b001);

    for (int r = 0; r < 40; r++) begin
      ra = $urandom;
      case (r % 3)
        0: rb = $urandom;
        1: rb = ra;
        default: rb = ra ^ (32'd1 << $urandom_range(0, W - 1));
      endcase
      tg = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", r), ra, rb, tg, model_res(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_msb_comparator.md
Name: serial_msb_comparator

Overview:
- Consumes two serial bit streams, A and B, presented MSB-first one bit pair per cycle, and produces an unsigned magnitude verdict (gt/eq/lt) after WIDTH pairs.
- Sits directly downstream of the two linear shift registers in the sequential unsigned comparator; each register's serial output drives bit_a or bit_b.
- The top level sequences start/bit_valid and collects the registered result.

Parameters:
- WIDTH, 32, operand width in bits; number of bit pairs consumed per comparison; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, synchronous, active-low; sampled on posedge clk.
- start, input, 1, begins a new comparison; accepted in any state.
- bit_valid, input, 1, bit_a/bit_b carry a valid pair this cycle.
- bit_a, input, 1, current bit of operand A, MSB-first.
- bit_b, input, 1, current bit of operand B, MSB-first.
- busy, output, 1, high while in COMPARE.
- done, output, 1, one-cycle pulse when the verdict becomes valid.
- gt, output, 1, A > B; registered and held until the next start.
- eq, output, 1, A == B; registered and held.
- lt, output, 1, A < B; registered and held.

Behaviour:
- Reset (reset==0 at posedge) overrides everything, including mid-comparison:
  - state=IDLE, cnt=0, decided=0.
  - busy=0, done=0, gt=0, eq=0, lt=0.
- States:
  - IDLE: wait for start.
  - COMPARE: consume bit pairs.
  - DONE: one cycle; done=1; then IDLE.
- Starting a comparison:
  - start=1 at an edge -> next state COMPARE, cnt=0, decided=0, gt/eq/lt cleared to 0, done=0, busy=1.
  - The bit pair present in the start cycle is NOT consumed.
- COMPARE, per edge with bit_valid=1:
  - Accept the pair; cnt increments.
  - If decided==0 and bit_a!=bit_b: decided=1, dir=bit_a. The first differing bit (MSB-most) wins; all later pairs are ignored for the verdict but still counted.
- COMPARE, bit_valid=0: stall; nothing changes.
- Last pair: the edge accepting the pair with cnt==WIDTH-1:
  - next state DONE, busy=0, done=1.
  - gt = decided&dir; lt = decided&~dir; eq = ~decided.
  - Exactly one of gt/eq/lt is high after any completed comparison.
- Latency: done is visible in the cycle immediately after the edge that accepts the WIDTH-th pair. With bit_valid held high, done asserts WIDTH cycles after the start edge.
- DONE -> IDLE unconditionally; gt/eq/lt persist through IDLE.
- start during COMPARE aborts the current comparison and restarts (cnt=0, flags cleared). Any partial result is discarded and done is not pulsed for the aborted run.
- start during DONE: done still pulses that cycle; next state COMPARE with flags cleared.
- start and reset together: reset wins.
- bit_valid outside COMPARE is ignored.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_DONE_EN.
- Defined: on the edge where the first differing pair is accepted, go straight to DONE with the verdict (done=1, busy=0). Remaining serial bits are not consumed. Equal operands still take WIDTH pairs.
- Undefined: always consume exactly WIDTH pairs before done.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, COMPARE, DONE}, 2 bits.
  - localparam function for CNT_W.
  - result encoding constants (GT/EQ/LT one-hot, 3 bits) shared with the top-level comparator.
- One sub-module: serial_bit_counter. CNT_W-bit up-counter with clear, enable and terminal-count (==WIDTH-1) output; synchronous active-low reset.

Test Plan:
- A=32'hFFFF_FFFF, B=32'h0000_0000, bit_valid always 1 -> done 32 cycles after start; gt=1, eq=0, lt=0.
- A=B=32'hDEAD_BEEF -> done after 32 accepted pairs; eq=1; flags held 5 idle cycles later.
- A=32'h7FFF_FFFF, B=32'h8000_0000 -> lt=1 (MSB decides; 31 later pairs with A>B ignored). With SERIAL_CMP_EARLY_DONE_EN: done 1 cycle after the first accepted pair.
- bit_valid toggling 1/0 each cycle, A=32'h0000_0001, B=32'h0000_0000 -> done 64 cycles after start; gt=1; busy high throughout.
- start re-asserted after 10 accepted pairs, new A=5, B=9 -> no done pulse for the first run; done 32 pairs after the restart; lt=1.
- reset driven low after 20 pairs -> next cycle all outputs 0, busy=0; no done pulse; a fresh start completes normally.
